alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked signed ALU with WIDTH-bit signed operands, a 3-bit opcode and a registered 2*WIDTH-bit signed result with status flags. It is the successor to the fixed 4-bit, 4-opcode ALU. It adds valid/ready flow control, four logic opcodes, an iterative signed multiply (multi-cycle, FSM-driven), and zero/negative/overflow flags. It sits between an operand producer and a result consumer, both using valid/ready.

## Interface

Parameters:

- WIDTH, 4: operand width in bits, two's complement; legal range 2..32.
- OUT_W, 2*WIDTH: result width; fixed derived value, not overridable.

Ports:

- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operand/opcode bundle is valid.
- in_ready  output  1  block accepts the bundle this cycle.
- A  input  WIDTH  signed operand A.
- B  input  WIDTH  signed operand B.
- opcode  input  3  operation select.
- out_valid  output  1  C and flags hold a result.
- out_ready  input  1  consumer takes the result this cycle.
- C  output  OUT_W  signed result.
- flag_z  output  1  C == 0.
- flag_n  output  1  C[OUT_W-1].
- flag_v  output  1  true result does not fit in WIDTH signed bits.

## Operation

- Accept: in_valid && in_ready at a rising edge.
- Opcodes (A, B signed; results sign-extended to OUT_W unless noted):
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 NOT: ~A.
  - 011 ROR: |B, zero-extended.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 MUL: A*B, full signed product.
- Arithmetic is exact in OUT_W bits; no wrap occurs for any opcode.
- flag_v: set when C lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Always 0 for opcodes 010–110.
- FSM states:
  - IDLE: ready for a new operation.
  - MUL: iterative multiply in progress.
- Transitions:
  - IDLE→MUL on accepting opcode 111.
  - MUL→IDLE after WIDTH iterations, writing the product to the output register.
  - All other opcodes stay in IDLE.
- MUL algorithm: latch |A|, |B| and the sign A[W−1]^B[W−1]; one shift-add per cycle; conditional negate on the final write.
  - |−2^(W−1)| is held as an unsigned WIDTH-bit value.
- Output register: single entry.
  - Cleared (out_valid←0) on out_valid && out_ready unless a new result is written in the same edge.
  - A written result has priority over the clear.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from state, out_valid and out_ready only, never from in_valid.
- While out_valid && !out_ready: C and all flags hold stable. in_ready is 0.
- Opcode X/unused: not possible, since all 8 codes are defined.

## Timing

- Reset (sync, at the edge where reset=1): state=IDLE, out_valid=0, C=0, flag_z=0, flag_n=0, flag_v=0. Any multiply in flight is discarded with no output.
- Reset dominates accept and handshake events in the same cycle.
- Single-cycle opcodes: accept at edge k → out_valid=1 with the result after edge k (latency 1).
- Full throughput: with out_ready held at 1, one result per cycle.
- MUL: accept at edge k → in_ready=0 from after edge k → result with out_valid=1 after edge k+WIDTH. in_ready returns to 1 in the same cycle as that result.
- MUL never blocks at completion: it can only start when the output slot is free by the accept edge.

## Structure

- Package alu_pipe_pkg holds:
  - opcode enum (ADD, SUB, NOT, ROR, AND, OR, XOR, MUL), 3 bits;
  - FSM state enum (IDLE, MUL).
- Sub-module alu_pipe_mul: the iterative signed multiplier.
  - Inputs: start, a, b.
  - Outputs: done, product.
  - Parametrised by WIDTH.
- The top level keeps the combinational single-cycle datapath, handshake logic, output register and flags.

## Test plan

All scenarios use WIDTH=4, OUT_W=8.

- ADD: A=0110, B=1011, out_ready=1 → one cycle later C=0000_0001, z=0, n=0, v=0.
- SUB: A=0110, B=1011 → C=0000_1011 (+11), v=1. NOT A=0110 → C=1111_1001, n=1, v=0. ROR B=0000 → C=0, z=1.
- MUL: A=1000, B=1000 → in_ready=0 for 4 cycles; C=0100_0000 (+64), v=1 at cycle 4. Also check A=0011, B=1110 → C=1111_1010.
- Backpressure: ADD accepted with out_ready=0 → C holds 3 cycles and in_ready=0. Raise out_ready together with in_valid (XOR 0101,0011) → new C=0000_0110 on the next cycle with no bubble.
- Reset mid-MUL: assert reset at cycle 2 of a multiply → after that edge out_valid=0, C=0, in_ready=1. No product is ever emitted.
- Back-to-back stream of 16 random single-cycle ops with out_ready=1 → 16 consecutive results, each matching a reference model.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared types for the handshaked signed ALU.
//   opcode_e : 3-bit operation select; all eight codes are defined
//   state_e  : control FSM states (idle / iterative multiply running)
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_ROR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand and result channels of alu_pipe, both valid/ready.
//   in_valid/in_ready   : operand bundle handshake (A, B, opcode)
//   out_valid/out_ready : result handshake (C, flag_z, flag_n, flag_v)
//   master modport      : producer/consumer side
//   slave modport       : the ALU itself
interface alu_pipe_if #(
  parameter int WIDTH = 4
);
  localparam int OUT_W = 2 * WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] C;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, C, flag_z, flag_n, flag_v
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, C, flag_z, flag_n, flag_v
  );

endinterface

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: iterative signed multiplier, one shift-add step per cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : latch a/b and begin a new product
//   a, b         : WIDTH-bit signed operands
//   done         : high in the cycle whose closing edge completes the product
//   product      : 2*WIDTH-bit signed product, valid while done is high
module alu_pipe_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int OUT_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  logic             busy;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [OUT_W-1:0] acc_next;

  // Magnitudes are held unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits.
  // The final step's sum is exposed combinationally so the top can register
  // the product on the WIDTH-th edge after start.
  always_comb begin
    a_mag    = a[WIDTH-1] ? -a : a;
    b_mag    = b[WIDTH-1] ? -b : b;
    acc_next = mplier[0] ? acc + mcand : acc;
    done     = busy && (count == CNT_W'(WIDTH - 1));
    product  = neg ? -acc_next : acc_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked signed ALU with a single-entry registered result.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready with A, B, opcode;
//                  out_valid/out_ready with C (2*WIDTH signed) and
//                  flag_z (C==0), flag_n (sign of C), flag_v (C outside
//                  the WIDTH-bit signed range)
// Single-cycle opcodes produce a result one edge after acceptance; MUL runs
// WIDTH cycles in alu_pipe_mul while in_ready is held low.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  alu_pipe_if.slave  bus
);

  localparam int OUT_W = 2 * WIDTH;

  state_e           state;
  state_e           state_next;
  opcode_e          op;
  logic             in_ready;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [OUT_W-1:0] mul_product;
  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic [OUT_W-1:0] alu_result;
  logic [OUT_W-1:0] wr_result;
  logic             wr_en;
  logic             wr_arith;
  logic             wr_v;
  logic             out_valid_q;
  logic [OUT_W-1:0] c_q;
  logic             z_q;
  logic             n_q;
  logic             v_q;

  assign op = opcode_e'(bus.opcode);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && op == OP_MUL) state_next = ST_MUL;
      ST_MUL:  if (mul_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // in_ready never looks at in_valid, so the producer may wait on it freely.
  // A MUL can only start when the output slot is free by the accept edge,
  // which guarantees its completion never has to stall.
  always_comb begin
    in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    accept    = bus.in_valid && in_ready;
    mul_start = accept && (op == OP_MUL);
  end

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Operands are sign-extended to OUT_W first so ADD/SUB are exact.
  always_comb begin
    a_ext = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
    b_ext = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
    case (op)
      OP_ADD:  alu_result = a_ext + b_ext;
      OP_SUB:  alu_result = a_ext - b_ext;
      OP_NOT:  alu_result = ~a_ext;
      OP_ROR:  alu_result = {{(OUT_W-1){1'b0}}, |bus.B};
      OP_AND:  alu_result = a_ext & b_ext;
      OP_OR:   alu_result = a_ext | b_ext;
      OP_XOR:  alu_result = a_ext ^ b_ext;
      default: alu_result = '0;
    endcase
  end

  // A result fits WIDTH signed bits exactly when its top WIDTH+1 bits agree.
  // Logic opcodes never raise overflow.
  always_comb begin
    wr_en     = (accept && op != OP_MUL) || mul_done;
    wr_result = mul_done ? mul_product : alu_result;
    wr_arith  = mul_done || op == OP_ADD || op == OP_SUB;
    wr_v      = wr_arith && !(&wr_result[OUT_W-1:WIDTH-1] || ~|wr_result[OUT_W-1:WIDTH-1]);
  end

  // A freshly written result wins over the consumer clearing the slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
    end else if (wr_en) begin
      out_valid_q <= 1'b1;
      c_q         <= wr_result;
      z_q         <= (wr_result == '0);
      n_q         <= wr_result[OUT_W-1];
      v_q         <= wr_v;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.C         = c_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe at WIDTH=4.
// A monitor pushes the reference result of every accepted bundle into a
// queue and pops/compares it whenever a result is handed to the consumer.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic random_ready = 1'b0;
  int   assertions = 0;
  int   failures = 0;
  logic [10:0] sb[$];

  alu_pipe_if #(.WIDTH(WIDTH)) bus();

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference: exact integer arithmetic on the signed operand values.
  // Returns {C[7:0], z, n, v}.
  function automatic logic [10:0] refModel(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa;
    int sbv;
    int r;
    int lo;
    int hi;
    logic v;
    logic [31:0] rbits;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    lo  = -(1 << (WIDTH - 1));
    hi  = (1 << (WIDTH - 1)) - 1;
    case (op)
      3'd0:    r = sa + sbv;
      3'd1:    r = sa - sbv;
      3'd2:    r = -sa - 1;
      3'd3:    r = (b != 4'd0) ? 1 : 0;
      3'd4:    r = sa & sbv;
      3'd5:    r = sa | sbv;
      3'd6:    r = sa ^ sbv;
      default: r = sa * sbv;
    endcase
    v = (op == 3'd0 || op == 3'd1 || op == 3'd7) && (r < lo || r > hi);
    rbits = r;
    return {rbits[7:0], (r == 0), (r < 0), v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a bundle and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic accepted;
    accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A        = a;
    bus.B        = b;
    for (int i = 0; i < 64 && !accepted; i++) begin
      if (random_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clock);
      accepted = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 64 cycles");
    end
  endtask

  function automatic logic [10:0] outVec();
    return {bus.C, bus.flag_z, bus.flag_n, bus.flag_v};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    time t0;
    logic [2:0] rop;

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;

    fork
      forever begin
        @(negedge clock);
        if (reset) begin
          sb.delete();
        end else begin
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
              assertions++;
              failures++;
              $display("[TB] FAIL sb_unexpected: got result %0h, required no output", outVec());
            end else begin
              checkOutput("scoreboard", 32'(outVec()), 32'(sb.pop_front()));
            end
          end
          if (bus.in_valid && bus.in_ready)
            sb.push_back(refModel(bus.opcode, bus.A, bus.B));
        end
      end
    join_none

    repeat (2) tick();
    reset = 1'b0;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_c_flags", 32'(outVec()), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus(OP_ADD, 4'b0110, 4'b1011);
    checkOutput("add_latency", 32'(bus.out_valid), 32'd1);
    checkOutput("add_result", 32'(outVec()), 32'({8'h01, 3'b000}));
    applyStimulus(OP_SUB, 4'b0110, 4'b1011);
    checkOutput("sub_result", 32'(outVec()), 32'({8'h0B, 3'b001}));
    applyStimulus(OP_NOT, 4'b0110, 4'b0000);
    checkOutput("not_result", 32'(outVec()), 32'({8'hF9, 3'b010}));
    applyStimulus(OP_ROR, 4'b0110, 4'b0000);
    checkOutput("ror_result", 32'(outVec()), 32'({8'h00, 3'b100}));

    applyStimulus(OP_MUL, 4'b1000, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mul_in_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
    end
    checkOutput("mul_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mul_result", 32'(outVec()), 32'({8'h40, 3'b001}));
    checkOutput("mul_in_ready_back", 32'(bus.in_ready), 32'd1);
    applyStimulus(OP_MUL, 4'b0011, 4'b1110);
    repeat (4) tick();
    checkOutput("mul_neg_result", 32'(outVec()), 32'({8'hFA, 3'b010}));
    tick();

    bus.out_ready = 1'b0;
    applyStimulus(OP_ADD, 4'b0011, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_hold_value", 32'(outVec()), 32'({8'h05, 3'b000}));
      checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    t0 = $time;
    applyStimulus(OP_XOR, 4'b0101, 4'b0011);
    checkOutput("bp_accept_cycles", 32'(($time - t0) / 10), 32'd1);
    checkOutput("bp_no_bubble_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_no_bubble_value", 32'(outVec()), 32'({8'h06, 3'b000}));
    tick();

    applyStimulus(OP_MUL, 4'b0101, 4'b0011);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_reset_c", 32'(bus.C), 32'd0);
    checkOutput("mid_reset_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (8) tick();
    checkOutput("mid_reset_no_product", 32'(bus.out_valid), 32'd0);

    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 6));
      applyStimulus(rop, 4'($urandom), 4'($urandom));
    end
    checkOutput("stream_cycles", 32'(($time - t0) / 10), 32'd16);
    repeat (2) tick();

    random_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      applyStimulus(rop, 4'($urandom), 4'($urandom));
    end
    random_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
